// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter: FSM states, data width and
// the baud divider calculation.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } uart_state_e;

  // Integer division; any fractional part of the ratio is a baud error the caller accepts.
  function automatic int unsigned calc_clks_per_bit(input int unsigned clk_freq_hz,
                                                    input int unsigned baud_rate);
    return clk_freq_hz / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_done on the
// last count of every bit period. Held at zero while disabled.
module uart_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic bit_done
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (!enable || (cnt_q == LAST_CNT)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bit_done = enable && (cnt_q == LAST_CNT);

endmodule

// File: rtl/uart_tx.sv
// Byte-wide UART transmitter, LSB first, 8N1 by default or 8E1 when UART_TX_PARITY_EN
// is defined. tx and busy come straight from flops.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned BAUD_RATE   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       start,
  output logic       tx,
  output logic       busy
);

  localparam int unsigned CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned BIT_W = $clog2(DATA_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e          state_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic                 tx_q;
  logic                 busy_q;
  logic                 baud_en;
  logic                 bit_done;
  logic                 next_bit;

  // Timer runs only inside a frame so every bit is phase-aligned to acceptance.
  assign baud_en = (state_q != StIdle);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .enable   (baud_en),
    .bit_done (bit_done)
  );

  assign next_bit = shreg_q[bit_cnt_q + BIT_W'(1)];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          bit_cnt_q <= '0;
          if (start) begin
            shreg_q <= data_in;
            state_q <= StStart;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        StStart: begin
          if (bit_done) begin
            state_q   <= StData;
            bit_cnt_q <= '0;
            tx_q      <= shreg_q[0];
          end
        end
        StData: begin
          if (bit_done) begin
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state_q <= StParity;
              tx_q    <= ^shreg_q;
`else
              state_q <= StStop;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
              tx_q      <= next_bit;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle, plus a frame
// monitor whose captures are compared against hand-computed bit patterns.
module tb_uart_tx;

  localparam int N = 50_000_000 / 115200;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME = 11;
  localparam logic [10:0] EXP_A5 = 11'h54A;
  localparam logic [10:0] EXP_00 = 11'h400;
  localparam logic [10:0] EXP_55 = 11'h4AA;
  localparam logic [10:0] EXP_3C = 11'h478;
  localparam logic [10:0] EXP_01 = 11'h602;
  localparam int          EXP_LEN = 4774;
`else
  localparam int FRAME = 10;
  localparam logic [10:0] EXP_A5 = 11'h34A;
  localparam logic [10:0] EXP_00 = 11'h200;
  localparam logic [10:0] EXP_55 = 11'h2AA;
  localparam logic [10:0] EXP_3C = 11'h278;
  localparam logic [10:0] EXP_01 = 11'h202;
  localparam int          EXP_LEN = 4340;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx dut (
    .clk     (clk),
    .rst     (rst),
    .data_in (data_in),
    .start   (start),
    .tx      (tx),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level of frame bit idx for byte d: start, data LSB first, [parity], stop.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // Reference model: a frame is just "accepted at some edge, then FRAME*N cycles long".
  bit         m_active = 1'b0;
  int         m_off = 0;
  logic [7:0] m_data = 8'h00;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_off    <= 0;
    end else if (m_active) begin
      if (m_off == FRAME * N - 1) m_active <= 1'b0;
      else m_off <= m_off + 1;
    end else if (start) begin
      m_active <= 1'b1;
      m_off    <= 0;
      m_data   <= data_in;
    end
  end

  always @(negedge clk) begin
    #1;
    check("cycle_busy", 32'(busy), 32'(m_active));
    check("cycle_tx", 32'(tx), m_active ? 32'(frame_bit(m_data, m_off / N)) : 32'd1);
  end

  // Frame monitor: samples tx mid-bit, records length and the idle gap before each frame.
  int          frames_done = 0;
  int          mon_len = 0;
  int          idle_cnt = 0;
  int          last_len = 0;
  int          last_gap = 0;
  logic [10:0] mon_bits = '0;
  logic [10:0] last_bits = '0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    #1;
    if (busy) begin
      if (!prev_busy) begin
        last_gap = idle_cnt;
        mon_bits = '0;
        mon_len  = 0;
      end
      if ((mon_len % N == N / 2) && (mon_len / N < 11)) mon_bits[mon_len / N] = tx;
      mon_len++;
    end else begin
      if (prev_busy) begin
        last_len  = mon_len;
        last_bits = mon_bits;
        frames_done++;
        idle_cnt  = 0;
      end
      idle_cnt++;
    end
    prev_busy = busy;
  end

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    checks++;
    if (frames_done < target) begin
      errors++;
      $display("FAIL %s: timeout, frames %0d required %0d", name, frames_done, target);
    end
  endtask

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    data_in = d;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    data_in = ~d;
  endtask

  initial begin
    int f0;
    rst = 1'b1;
    #100;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("post_reset_tx", 32'(tx), 32'd1);
    check("post_reset_busy", 32'(busy), 32'd0);

    // Single A5 frame
    f0 = frames_done;
    pulse_start(8'hA5);
    #2;
    check("busy_rise", 32'(busy), 32'd1);
    wait_frames(f0 + 1, FRAME * N + 100, "a5_frame");
    check("a5_len", 32'(last_len), 32'(EXP_LEN));
    check("a5_bits", 32'(last_bits), 32'(EXP_A5));
    repeat (50) @(negedge clk);
    #2;
    check("idle_after_tx", 32'(tx), 32'd1);
    check("idle_after_busy", 32'(busy), 32'd0);

    // start pulse mid-frame must be ignored
    f0 = frames_done;
    pulse_start(8'hA5);
    repeat (2000) @(negedge clk);
    data_in = 8'hFF;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    wait_frames(f0 + 1, FRAME * N + 100, "ignore_frame");
    check("ignore_bits", 32'(last_bits), 32'(EXP_A5));
    check("ignore_len", 32'(last_len), 32'(EXP_LEN));
    repeat (200) @(negedge clk);
    #2;
    check("no_second_frame", 32'(frames_done), 32'(f0 + 1));
    check("no_second_busy", 32'(busy), 32'd0);

    // Back-to-back with start held high
    f0 = frames_done;
    @(negedge clk);
    data_in = 8'h00;
    start   = 1'b1;
    @(negedge clk);
    data_in = 8'h55;
    wait_frames(f0 + 1, FRAME * N + 100, "b2b_first");
    check("b2b_first_bits", 32'(last_bits), 32'(EXP_00));
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_frames(f0 + 2, FRAME * N + 100, "b2b_second");
    check("b2b_second_bits", 32'(last_bits), 32'(EXP_55));
    check("b2b_gap", 32'(last_gap), 32'd1);
    check("b2b_second_len", 32'(last_len), 32'(EXP_LEN));

    // Asynchronous reset during data bit 3
    pulse_start(8'hA5);
    repeat (4 * N + 100) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_tx", 32'(tx), 32'd1);
    check("rst_async_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    f0 = frames_done;
    pulse_start(8'h3C);
    wait_frames(f0 + 1, FRAME * N + 100, "after_rst_frame");
    check("after_rst_bits", 32'(last_bits), 32'(EXP_3C));
    check("after_rst_len", 32'(last_len), 32'(EXP_LEN));

    // Single set bit: exercises LSB position and, with parity, an odd-weight byte
    f0 = frames_done;
    pulse_start(8'h01);
    wait_frames(f0 + 1, FRAME * N + 100, "x01_frame");
    check("x01_bits", 32'(last_bits), 32'(EXP_01));
    check("x01_len", 32'(last_len), 32'(EXP_LEN));

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
